digit_serial_adder: RTL

//   Multi-cycle, parametrised successor to the single-bit full adder: adds two WIDTH-bit operands plus carry-in,

---
 rtl/digit_serial_adder_pkg.sv | 18 +
 rtl/digit_serial_adder_digit.sv | 25 ++
 rtl/digit_serial_adder.sv | 117 +++++++++++
 3 files changed

// File: rtl/digit_serial_adder_pkg.sv
// Shared types and elaboration-time helpers for the digit-serial adder.
package adder_pkg;

    typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

    // Step-counter width: $clog2(WIDTH/DIGIT)+1, guarded against an illegal DIGIT of 0.
    function automatic int step_cnt_width(input int width, input int digit);
        if (digit < 1) return 1;
        return $clog2(width / digit) + 1;
    endfunction

    function automatic bit params_legal(input int width, input int digit);
        if (digit < 1) return 1'b0;
        if (digit > width) return 1'b0;
        return (width % digit) == 0;
    endfunction

endpackage

// File: rtl/digit_serial_adder_digit.sv
// DIGIT-bit combinational ripple-carry slice built from full-adder cells.
module digit_adder #(
    parameter int DIGIT = 4
) (
    input  logic [DIGIT-1:0] a,
    input  logic [DIGIT-1:0] b,
    input  logic             ci,
    output logic [DIGIT-1:0] s,
    output logic             co
);

    logic [DIGIT:0] c;

    always_comb begin
        c    = '0;
        s    = '0;
        c[0] = ci;
        for (int unsigned i = 0; i < DIGIT; i++) begin
            s[i]     = a[i] ^ b[i] ^ c[i];
            c[i+1]   = (a[i] & b[i]) | (c[i] & (a[i] ^ b[i]));
        end
        co = c[DIGIT];
    end

endmodule

// File: rtl/digit_serial_adder.sv
// Digit-serial adder: WIDTH-bit a+b+cin, DIGIT bits per clock, start/busy/done handshake.
// Optional subtract mode enabled by defining DIGIT_SERIAL_ADD_SUB_EN (adds the sub port).
module digit_serial_adder
    import adder_pkg::*;
#(
    parameter int WIDTH = 16,
    parameter int DIGIT = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             cin,
`ifdef DIGIT_SERIAL_ADD_SUB_EN
    input  logic             sub,
`endif
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] sum,
    output logic             cout
);

    localparam int STEPS = WIDTH / DIGIT;
    localparam int CW    = step_cnt_width(WIDTH, DIGIT);
    localparam logic [CW-1:0] LAST = CW'(STEPS - 1);

    if (!params_legal(WIDTH, DIGIT)) begin : g_bad_params
        $error("digit_serial_adder: WIDTH (%0d) must be a multiple of DIGIT (%0d), DIGIT >= 1",
               WIDTH, DIGIT);
    end

    state_t           state;
    logic [CW-1:0]    cnt;
    logic [WIDTH-1:0] a_sh;
    logic [WIDTH-1:0] b_sh;
    logic             carry;
    logic [WIDTH-1:0] b_in;
    logic             c_in;
    logic [DIGIT-1:0] ds;
    logic             dco;
    logic [WIDTH-1:0] sum_next;

`ifdef DIGIT_SERIAL_ADD_SUB_EN
    // Two's-complement subtract: invert B and force the initial carry to 1.
    always_comb begin
        b_in = sub ? ~b : b;
        c_in = sub ? 1'b1 : cin;
    end
`else
    always_comb begin
        b_in = b;
        c_in = cin;
    end
`endif

    // New digit enters at the MSB end so the full result is aligned after STEPS shifts.
    always_comb begin
        sum_next                   = sum >> DIGIT;
        sum_next[WIDTH-1 -: DIGIT] = ds;
    end

    digit_adder #(.DIGIT(DIGIT)) u_digit (
        .a  (a_sh[DIGIT-1:0]),
        .b  (b_sh[DIGIT-1:0]),
        .ci (carry),
        .s  (ds),
        .co (dco)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= IDLE;
            cnt   <= '0;
            a_sh  <= '0;
            b_sh  <= '0;
            carry <= 1'b0;
            sum   <= '0;
            cout  <= 1'b0;
            busy  <= 1'b0;
            done  <= 1'b0;
        end else begin
            case (state)
                IDLE, DONE: begin
                    done <= 1'b0;
                    if (start) begin
                        a_sh  <= a;
                        b_sh  <= b_in;
                        carry <= c_in;
                        cnt   <= '0;
                        busy  <= 1'b1;
                        state <= RUN;
                    end else begin
                        state <= IDLE;
                    end
                end
                RUN: begin
                    a_sh  <= a_sh >> DIGIT;
                    b_sh  <= b_sh >> DIGIT;
                    carry <= dco;
                    sum   <= sum_next;
                    if (cnt == LAST) begin
                        cnt   <= '0;
                        cout  <= dco;
                        busy  <= 1'b0;
                        done  <= 1'b1;
                        state <= DONE;
                    end else begin
                        cnt <= cnt + CW'(1);
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule
